logic_pipe: RTL and testbench

//   Parametrised, pipelined logic/shift unit for the Tinker execute stage; successor to the fixed 64-bit logic unit.

---
 rtl/logic_pipe_if.sv | 39 +++
 rtl/logic_pipe.sv | 111 +++++++++++
 tb/tb_logic_pipe.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/logic_pipe_if.sv
// Handshake/operand bundle for logic_pipe: issue side (in_*) and writeback side (out_*).
// out_zero exists only when LOGIC_PIPE_FLAGS_EN is defined.
interface logic_pipe_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       ctrl;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dst;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;
`ifdef LOGIC_PIPE_FLAGS_EN
    logic             out_zero;

    modport master (
        output in_valid, ctrl, op1, op2, in_tag, out_ready,
        input  in_ready, out_valid, dst, out_tag, out_err, out_zero
    );
    modport slave (
        input  in_valid, ctrl, op1, op2, in_tag, out_ready,
        output in_ready, out_valid, dst, out_tag, out_err, out_zero
    );
`else
    modport master (
        output in_valid, ctrl, op1, op2, in_tag, out_ready,
        input  in_ready, out_valid, dst, out_tag, out_err
    );
    modport slave (
        input  in_valid, ctrl, op1, op2, in_tag, out_ready,
        output in_ready, out_valid, dst, out_tag, out_err
    );
`endif
endinterface

// File: rtl/logic_pipe.sv
// Pipelined logic/shift unit with valid/ready backpressure and collapsing bubbles.
// Optional zero flag enabled by defining LOGIC_PIPE_FLAGS_EN.
module logic_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic         clk,
    input  logic         rst,
    logic_pipe_if.slave  bus
);
    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH-1:0] w_result;
    logic             w_err;
    logic [SH_W-1:0]  w_shamt;

    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_err;
    logic [WIDTH-1:0]  r_dst [STAGES];
    logic [TAG_W-1:0]  r_tag [STAGES];

    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;
    logic              w_free;

`ifdef LOGIC_PIPE_FLAGS_EN
    logic [STAGES-1:0] r_zero;
    logic              w_zero;
    assign w_zero = (w_result == '0);
`endif

    // Only the low log2(WIDTH) bits of op2 form the shift amount.
    assign w_shamt = bus.op2[SH_W-1:0];

    always_comb begin
        w_result = '0;
        w_err    = 1'b0;
        case (bus.ctrl)
            3'd0:    w_result = bus.op1 & bus.op2;
            3'd1:    w_result = bus.op1 | bus.op2;
            3'd2:    w_result = bus.op1 ^ bus.op2;
            3'd3:    w_result = ~bus.op1;
            3'd4:    w_result = bus.op1 >> w_shamt;
            3'd5:    w_result = bus.op1 << w_shamt;
            default: w_err    = 1'b1;
        endcase
    end

    // Walk from the output back: a stage can load if it is empty or its occupant moves on.
    always_comb begin
        w_adv  = '0;
        w_load = '0;
        w_free = bus.out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_adv[i]  = r_valid[i] && w_free;
            w_load[i] = !r_valid[i] || w_adv[i];
            w_free    = w_load[i];
        end
    end

    assign bus.in_ready = w_load[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_err   <= '0;
`ifdef LOGIC_PIPE_FLAGS_EN
            r_zero  <= '0;
`endif
            for (int i = 0; i < STAGES; i++) begin
                r_dst[i] <= '0;
                r_tag[i] <= '0;
            end
        end else begin
            if (w_load[0]) begin
                r_valid[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    r_dst[0] <= w_result;
                    r_tag[0] <= bus.in_tag;
                    r_err[0] <= w_err;
`ifdef LOGIC_PIPE_FLAGS_EN
                    r_zero[0] <= w_zero;
`endif
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (w_load[i]) begin
                    r_valid[i] <= r_valid[i-1];
                    if (r_valid[i-1]) begin
                        r_dst[i] <= r_dst[i-1];
                        r_tag[i] <= r_tag[i-1];
                        r_err[i] <= r_err[i-1];
`ifdef LOGIC_PIPE_FLAGS_EN
                        r_zero[i] <= r_zero[i-1];
`endif
                    end
                end
            end
        end
    end

    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.dst       = r_dst[STAGES-1];
    assign bus.out_tag   = r_tag[STAGES-1];
    assign bus.out_err   = r_err[STAGES-1];
`ifdef LOGIC_PIPE_FLAGS_EN
    assign bus.out_zero  = r_zero[STAGES-1];
`endif

endmodule

// File: tb/tb_logic_pipe.sv
// Directed bench for logic_pipe: a 64-bit/2-stage instance and an 8-bit/1-stage instance.
// Zero-flag checks are compiled in when LOGIC_PIPE_FLAGS_EN is defined.
module tb_logic_pipe;
    logic clk = 1'b0;
    logic rst;
    int   nVectors     = 0;
    int   nMiscompares = 0;

    always #5 clk = ~clk;

    logic_pipe_if #(.WIDTH(64), .TAG_W(5)) bus64 ();
    logic_pipe_if #(.WIDTH(8),  .TAG_W(5)) bus8 ();

    logic_pipe #(.WIDTH(64), .STAGES(2), .TAG_W(5)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64)
    );

    logic_pipe #(.WIDTH(8), .STAGES(1), .TAG_W(5)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] c, input logic [63:0] a, input logic [63:0] b,
                                 input logic [4:0] t);
        bus64.in_valid = 1'b1;
        bus64.ctrl     = c;
        bus64.op1      = a;
        bus64.op2      = b;
        bus64.in_tag   = t;
    endtask

    task automatic idle64;
        bus64.in_valid = 1'b0;
    endtask

    task automatic expectResult(input string name, input logic [63:0] d, input logic [4:0] t,
                                input logic e);
        checkOutput({name, ".valid"}, 64'(bus64.out_valid), 64'd1);
        checkOutput({name, ".dst"},   bus64.dst,            d);
        checkOutput({name, ".tag"},   64'(bus64.out_tag),   64'(t));
        checkOutput({name, ".err"},   64'(bus64.out_err),   64'(e));
`ifdef LOGIC_PIPE_FLAGS_EN
        checkOutput({name, ".zero"},  64'(bus64.out_zero),  64'(d == 64'd0));
`endif
    endtask

    task automatic expectEmpty(input string name);
        checkOutput({name, ".valid"}, 64'(bus64.out_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus64.in_valid = 1'b0; bus64.ctrl = 3'd0; bus64.op1 = '0; bus64.op2 = '0;
        bus64.in_tag = '0; bus64.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.ctrl = 3'd0; bus8.op1 = '0; bus8.op2 = '0;
        bus8.in_tag = '0; bus8.out_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;

        checkOutput("rst.valid", 64'(bus64.out_valid), 64'd0);
        checkOutput("rst.ready", 64'(bus64.in_ready),  64'd1);
        checkOutput("rst.dst",   bus64.dst,            64'd0);
        checkOutput("rst.err",   64'(bus64.out_err),   64'd0);
        checkOutput("rst8.valid", 64'(bus8.out_valid), 64'd0);

        // Back-to-back ops at full throughput, two-cycle latency.
        applyStimulus(3'd0, 64'hF0F0, 64'hFF00, 5'd1);
        checkOutput("t1.ready", 64'(bus64.in_ready), 64'd1);
        tick;
        expectEmpty("t1.latency");
        applyStimulus(3'd1, 64'hF0F0, 64'hFF00, 5'd2);
        tick;
        expectResult("t1.and", 64'hF000, 5'd1, 1'b0);
        applyStimulus(3'd2, 64'hF0F0, 64'hFF00, 5'd3);
        tick;
        expectResult("t1.or", 64'hFFF0, 5'd2, 1'b0);
        applyStimulus(3'd3, 64'h0, 64'h1234, 5'd4);
        tick;
        expectResult("t1.xor", 64'h0FF0, 5'd3, 1'b0);
        applyStimulus(3'd5, 64'h1, 64'h140, 5'd5);
        tick;
        expectResult("t2.not", 64'hFFFF_FFFF_FFFF_FFFF, 5'd4, 1'b0);
        applyStimulus(3'd4, 64'h8000_0000_0000_0000, 64'd63, 5'd6);
        tick;
        expectResult("t2.shl", 64'h1, 5'd5, 1'b0);
        idle64;
        tick;
        expectResult("t2.shr", 64'h1, 5'd6, 1'b0);
        tick;
        expectEmpty("t2.drain");

        // Backpressure: the third op must wait until the consumer frees the pipe.
        bus64.out_ready = 1'b0;
        applyStimulus(3'd0, 64'hF0F0, 64'hFF00, 5'd1);
        checkOutput("t3.ready1", 64'(bus64.in_ready), 64'd1);
        tick;
        applyStimulus(3'd1, 64'hF0F0, 64'hFF00, 5'd2);
        checkOutput("t3.ready2", 64'(bus64.in_ready), 64'd1);
        tick;
        expectResult("t3.held1", 64'hF000, 5'd1, 1'b0);
        applyStimulus(3'd2, 64'hF0F0, 64'hFF00, 5'd3);
        checkOutput("t3.full", 64'(bus64.in_ready), 64'd0);
        tick;
        expectResult("t3.held2", 64'hF000, 5'd1, 1'b0);
        checkOutput("t3.stillFull", 64'(bus64.in_ready), 64'd0);
        bus64.out_ready = 1'b1;
        #1;
        checkOutput("t3.readyThru", 64'(bus64.in_ready), 64'd1);
        tick;
        idle64;
        expectResult("t3.tag2", 64'hFFF0, 5'd2, 1'b0);
        tick;
        expectResult("t3.tag3", 64'h0FF0, 5'd3, 1'b0);
        tick;
        expectEmpty("t3.drain");

        // Reserved opcodes and the following normal op.
        applyStimulus(3'd6, 64'hFF, 64'hFF, 5'd6);
        tick;
        applyStimulus(3'd7, 64'hFF, 64'hFF, 5'd7);
        tick;
        expectResult("t4.rsv6", 64'h0, 5'd6, 1'b1);
        applyStimulus(3'd0, 64'h1, 64'h2, 5'd8);
        tick;
        expectResult("t4.rsv7", 64'h0, 5'd7, 1'b1);
        applyStimulus(3'd0, 64'hFF, 64'h0F, 5'd9);
        tick;
        expectResult("t4.andZero", 64'h0, 5'd8, 1'b0);
        idle64;
        tick;
        expectResult("t4.andNz", 64'h0F, 5'd9, 1'b0);
        tick;

        // Reset with two ops in flight: neither may ever appear.
        bus64.out_ready = 1'b0;
        applyStimulus(3'd0, 64'hF0F0, 64'hFF00, 5'd10);
        tick;
        applyStimulus(3'd1, 64'hF0F0, 64'hFF00, 5'd11);
        tick;
        expectResult("t5.preRst", 64'hF000, 5'd10, 1'b0);
        idle64;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkOutput("t5.valid", 64'(bus64.out_valid), 64'd0);
        checkOutput("t5.ready", 64'(bus64.in_ready),  64'd1);
        checkOutput("t5.dst",   bus64.dst,            64'd0);
        checkOutput("t5.tag",   64'(bus64.out_tag),   64'd0);
        bus64.out_ready = 1'b1;
        tick;
        expectEmpty("t5.after1");
        tick;
        expectEmpty("t5.after2");

        // 8-bit, single-stage instance.
        bus8.in_valid = 1'b1; bus8.ctrl = 3'd2; bus8.op1 = 8'hAA; bus8.op2 = 8'hFF; bus8.in_tag = 5'd3;
        tick;
        checkOutput("t6.xorValid", 64'(bus8.out_valid), 64'd1);
        checkOutput("t6.xorDst",   64'(bus8.dst),       64'h55);
        checkOutput("t6.xorTag",   64'(bus8.out_tag),   64'd3);
        checkOutput("t6.ready",    64'(bus8.in_ready),  64'd1);
        bus8.ctrl = 3'd5; bus8.op1 = 8'h81; bus8.op2 = 8'h09; bus8.in_tag = 5'd4;
        tick;
        bus8.in_valid = 1'b0;
        checkOutput("t6.shlValid", 64'(bus8.out_valid), 64'd1);
        checkOutput("t6.shlDst",   64'(bus8.dst),       64'h02);
        checkOutput("t6.shlTag",   64'(bus8.out_tag),   64'd4);
        tick;
        checkOutput("t6.drain",    64'(bus8.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
